// File: rtl/bf_pkg.sv
// ============================================================================
// Module : bf_pkg
// Brief  : Opcode encodings, sequencer state type and PC-step codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bf_pkg;

  localparam logic [2:0] OP_DPINC = 3'b000;
  localparam logic [2:0] OP_DPDEC = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_OUT   = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_JNZ   = 3'b111;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SCAN_FWD  = 2'd1,
    SCAN_BACK = 2'd2
  } state_t;

  // Two-bit signed step codes, sign-extended to PC_W at the port
  localparam logic signed [1:0] PCD_STALL = 2'sb00;
  localparam logic signed [1:0] PCD_FWD   = 2'sb01;
  localparam logic signed [1:0] PCD_BACK  = 2'sb11;

endpackage

`default_nettype wire

// File: rtl/bf_sequencer_if.sv
// ============================================================================
// Module : bf_sequencer_if
// Brief  : Fetch / datapath / I/O handshake bundle around the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bf_sequencer_if #(
  parameter int PC_W = 16
);
  logic [2:0]      nextop;
  logic [PC_W-1:0] pcdelta;
  logic            cell_zero;
  logic            out_ready;
  logic            in_valid;
  logic            dp_inc;
  logic            dp_dec;
  logic            cell_inc;
  logic            cell_dec;
  logic            out_valid;
  logic            cell_load;

  modport master (
    input  nextop, cell_zero, out_ready, in_valid,
    output pcdelta, dp_inc, dp_dec, cell_inc, cell_dec, out_valid, cell_load
  );

  modport slave (
    output nextop, cell_zero, out_ready, in_valid,
    input  pcdelta, dp_inc, dp_dec, cell_inc, cell_dec, out_valid, cell_load
  );
endinterface

`default_nettype wire

// File: rtl/bf_depth_ctr.sv
// ============================================================================
// Module : bf_depth_ctr
// Brief  : Saturating bracket-depth counter, decrement-to-zero detect, sticky
//          overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bf_depth_ctr #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_one,
  input  logic               inc,
  input  logic               dec,
  output logic [DEPTH_W-1:0] depth,
  output logic               dec_zero,
  output logic               err
);

  assign dec_zero = (depth == DEPTH_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth <= '0;
      err   <= 1'b0;
    end else if (load_one) begin
      depth <= DEPTH_W'(1);
    end else if (inc) begin
      if (&depth) err   <= 1'b1;
      else        depth <= depth + DEPTH_W'(1);
    end else if (dec) begin
      if (depth != '0) depth <= depth - DEPTH_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/bf_sequencer.sv
// ============================================================================
// Module : bf_sequencer
// Brief  : Opcode sequencer with linear bracket scanning; optional counters
//          retired/scan_cycles enabled by macro BF_SEQ_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bf_sequencer
  import bf_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int DEPTH_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  bf_sequencer_if.master        bus,
`ifdef BF_SEQ_PERF_EN
  output logic [31:0]           retired,
  output logic [31:0]           scan_cycles,
`endif
  output logic                  depth_err
);

  state_t            state, state_n;
  logic signed [1:0] pcd;
  logic              ld_one, d_inc, d_dec, dec_zero;
  logic [DEPTH_W-1:0] depth;

  bf_depth_ctr #(.DEPTH_W(DEPTH_W)) u_depth (
    .clk      (clk),
    .rst      (rst),
    .load_one (ld_one),
    .inc      (d_inc),
    .dec      (d_dec),
    .depth    (depth),
    .dec_zero (dec_zero),
    .err      (depth_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    pcd           = PCD_STALL;
    ld_one        = 1'b0;
    d_inc         = 1'b0;
    d_dec         = 1'b0;
    bus.dp_inc    = 1'b0;
    bus.dp_dec    = 1'b0;
    bus.cell_inc  = 1'b0;
    bus.cell_dec  = 1'b0;
    bus.out_valid = 1'b0;
    bus.cell_load = 1'b0;
    // rst gates outputs so nothing fires while the async reset is held
    if (run && !rst) begin
      case (state)
        RUN: begin
          case (bus.nextop)
            OP_DPINC: begin bus.dp_inc   = 1'b1; pcd = PCD_FWD; end
            OP_DPDEC: begin bus.dp_dec   = 1'b1; pcd = PCD_FWD; end
            OP_INC:   begin bus.cell_inc = 1'b1; pcd = PCD_FWD; end
            OP_DEC:   begin bus.cell_dec = 1'b1; pcd = PCD_FWD; end
            OP_OUT: begin
              bus.out_valid = 1'b1;
              if (bus.out_ready) pcd = PCD_FWD;
            end
            OP_IN: begin
              if (bus.in_valid) begin
                bus.cell_load = 1'b1;
                pcd           = PCD_FWD;
              end
            end
            OP_JZ: begin
              pcd = PCD_FWD;
              if (bus.cell_zero) begin
                ld_one  = 1'b1;
                state_n = SCAN_FWD;
              end
            end
            OP_JNZ: begin
              if (bus.cell_zero) begin
                pcd = PCD_FWD;
              end else begin
                pcd     = PCD_BACK;
                ld_one  = 1'b1;
                state_n = SCAN_BACK;
              end
            end
          endcase
        end
        SCAN_FWD: begin
          // The match cycle still steps +1, landing just past the ']'
          pcd = PCD_FWD;
          if (bus.nextop == OP_JZ) begin
            d_inc = 1'b1;
          end else if (bus.nextop == OP_JNZ) begin
            d_dec = 1'b1;
            if (dec_zero) state_n = RUN;
          end
        end
        SCAN_BACK: begin
          pcd = PCD_BACK;
          if (bus.nextop == OP_JNZ) begin
            d_inc = 1'b1;
          end else if (bus.nextop == OP_JZ) begin
            d_dec = 1'b1;
            if (dec_zero) begin
              pcd     = PCD_FWD;
              state_n = RUN;
            end
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  assign bus.pcdelta = PC_W'(pcd);

`ifdef BF_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired     <= '0;
      scan_cycles <= '0;
    end else if (run) begin
      if (state == RUN && pcd != PCD_STALL) retired <= retired + 32'd1;
      if (state != RUN)                     scan_cycles <= scan_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bf_sequencer.sv
// ============================================================================
// Module : tb_bf_sequencer
// Brief  : Directed vector table plus program sequences with a fetch model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bf_sequencer;
  import bf_pkg::*;

  logic clk, rst, run, depth_err;
  logic [5:0]  stb;
  logic [15:0] pc;
  logic [2:0]  prog [0:31];
  int nvec, nerr;

  bf_sequencer_if #(.PC_W(16)) bus ();

  bf_sequencer #(.PC_W(16), .DEPTH_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .bus       (bus.master),
    .depth_err (depth_err)
  );

  assign stb = {bus.dp_inc, bus.dp_dec, bus.cell_inc, bus.cell_dec,
                bus.out_valid, bus.cell_load};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       run;
    logic [2:0] op;
    logic       cz;
    logic       ordy;
    logic       ival;
    logic [1:0] pcd;
    logic [5:0] stb;
  } vec_t;

  localparam logic [5:0] S_NONE = 6'b000000, S_DPI = 6'b100000,
                         S_DPD = 6'b010000, S_CI = 6'b001000,
                         S_CD = 6'b000100, S_OV = 6'b000010, S_LD = 6'b000001;

  task automatic chk(input string name, input logic [15:0] epcd, input logic [5:0] estb);
    nvec++;
    if ({bus.pcdelta, stb} !== {epcd, estb}) begin
      nerr++;
      $display("FAIL %s: got pcdelta=%h strobes=%b, expected pcdelta=%h strobes=%b",
               name, bus.pcdelta, stb, epcd, estb);
    end
  endtask

  task automatic chk_val(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One fetch-model cycle: check outputs, then advance PC by pcdelta
  task automatic step(input string name, input int epcd, input logic [5:0] estb);
    logic [15:0] d;
    @(negedge clk);
    chk(name, 16'(epcd), estb);
    d = bus.pcdelta;
    @(posedge clk);
    #1;
    pc = pc + d;
    bus.nextop = prog[pc[4:0]];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_prog(input string s, input logic [15:0] start);
    for (int i = 0; i < 32; i++) prog[i] = OP_DPINC;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        ">": prog[i] = OP_DPINC;
        "<": prog[i] = OP_DPDEC;
        "+": prog[i] = OP_INC;
        "-": prog[i] = OP_DEC;
        ".": prog[i] = OP_OUT;
        ",": prog[i] = OP_IN;
        "[": prog[i] = OP_JZ;
        default: prog[i] = OP_JNZ;
      endcase
    end
    pc = start;
    bus.nextop = prog[pc[4:0]];
  endtask

  vec_t tbl [0:12];
  int   dseq [0:6];

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1; run = 1'b1;
    bus.nextop = OP_INC; bus.cell_zero = 1'b0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    pc = '0;

    // Reset holds outputs low even with run=1 and an active opcode
    @(negedge clk);
    chk("reset_outputs", 16'h0000, S_NONE);
    chk_val("reset_depth_err", int'(depth_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    tbl[0]  = '{1'b0, OP_INC,   1'b0, 1'b0, 1'b0, 2'b00, S_NONE};
    tbl[1]  = '{1'b1, OP_DPINC, 1'b0, 1'b0, 1'b0, 2'b01, S_DPI};
    tbl[2]  = '{1'b1, OP_DPDEC, 1'b0, 1'b0, 1'b0, 2'b01, S_DPD};
    tbl[3]  = '{1'b1, OP_INC,   1'b0, 1'b0, 1'b0, 2'b01, S_CI};
    tbl[4]  = '{1'b1, OP_DEC,   1'b0, 1'b0, 1'b0, 2'b01, S_CD};
    tbl[5]  = '{1'b1, OP_OUT,   1'b0, 1'b0, 1'b0, 2'b00, S_OV};
    tbl[6]  = '{1'b1, OP_OUT,   1'b0, 1'b1, 1'b0, 2'b01, S_OV};
    tbl[7]  = '{1'b1, OP_IN,    1'b0, 1'b0, 1'b0, 2'b00, S_NONE};
    tbl[8]  = '{1'b1, OP_IN,    1'b0, 1'b0, 1'b1, 2'b01, S_LD};
    tbl[9]  = '{1'b1, OP_JZ,    1'b0, 1'b0, 1'b0, 2'b01, S_NONE};
    tbl[10] = '{1'b1, OP_JNZ,   1'b1, 1'b0, 1'b0, 2'b01, S_NONE};
    tbl[11] = '{1'b0, OP_JZ,    1'b1, 1'b0, 1'b0, 2'b00, S_NONE};
    tbl[12] = '{1'b0, OP_JNZ,   1'b0, 1'b0, 1'b0, 2'b00, S_NONE};

    for (int i = 0; i < 13; i++) begin
      run = tbl[i].run; bus.nextop = tbl[i].op; bus.cell_zero = tbl[i].cz;
      bus.out_ready = tbl[i].ordy; bus.in_valid = tbl[i].ival;
      @(negedge clk);
      chk($sformatf("table[%0d]", i), 16'($signed(tbl[i].pcd)), tbl[i].stb);
      @(posedge clk); #1;
    end
    run = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.cell_zero = 1'b0;

    // "+>+<-": one strobe per cycle
    do_reset();
    load_prog("+>+<-", 16'd0);
    step("seq1_c0", 1, S_CI);
    step("seq1_c1", 1, S_DPI);
    step("seq1_c2", 1, S_CI);
    step("seq1_c3", 1, S_DPD);
    step("seq1_c4", 1, S_CD);

    // '.' back-pressured for 3 cycles
    load_prog(".>", 16'd0);
    for (int i = 0; i < 3; i++) step($sformatf("out_wait%0d", i), 0, S_OV);
    bus.out_ready = 1'b1;
    step("out_accept", 1, S_OV);
    bus.out_ready = 1'b0;
    chk_val("out_pc", int'(pc), 1);

    // Forward scan over nested brackets
    load_prog("[+[-]+]>", 16'd0);
    bus.cell_zero = 1'b1;
    dseq = '{1, 1, 2, 2, 1, 1, 0};
    for (int i = 0; i < 7; i++) begin
      step($sformatf("fwd_c%0d", i), 1, S_NONE);
      chk_val($sformatf("fwd_depth%0d", i), int'(dut.u_depth.depth), dseq[i]);
    end
    step("fwd_exit", 1, S_DPI);

    // Backward scan from ']' at PC 3
    do_reset();
    load_prog("+[-]", 16'd3);
    bus.cell_zero = 1'b0;
    step("back_c0", -1, S_NONE);
    step("back_c1", -1, S_NONE);
    step("back_c2", 1, S_NONE);
    chk_val("back_pc", int'(pc), 2);
    chk_val("back_state", int'(dut.state), int'(RUN));
    step("back_exit", 1, S_CD);

    // Forward depth saturation at DEPTH_W=2
    do_reset();
    load_prog("[[[[[", 16'd0);
    bus.cell_zero = 1'b1;
    dseq = '{1, 2, 3, 3, 3, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step($sformatf("sat_c%0d", i), 1, S_NONE);
      chk_val($sformatf("sat_depth%0d", i), int'(dut.u_depth.depth), dseq[i]);
      chk_val($sformatf("sat_err%0d", i), int'(depth_err), (i >= 3) ? 1 : 0);
    end

    // Backward overflow with PC wrap, then async reset mid-SCAN_BACK
    do_reset();
    load_prog("]]]", 16'd2);
    prog[31] = OP_JNZ;
    prog[30] = OP_INC;
    bus.cell_zero = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("bsat_c%0d", i), -1, S_NONE);
    chk_val("bsat_pc", int'(pc), 16'hFFFE);
    chk_val("bsat_err", int'(depth_err), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_outputs", 16'h0000, S_NONE);
    chk_val("arst_err", int'(depth_err), 0);
    chk_val("arst_depth", int'(dut.u_depth.depth), 0);
    chk_val("arst_state", int'(dut.state), int'(RUN));
    @(posedge clk); #1;
    rst = 1'b0;
    step("arst_resume", 1, S_CI);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
